mux4_rr_arbiter: RTL and testbench

- Shares one 4:1 32-bit datapath mux between four requesters and feeds a single downstream consumer through a one-word output register.
- Round-robin arbitration with an optional bounded "lock" that lets one requester send back-to-back words.
- Drives the mux select and one-hot grant, and handles the ack (producer side) and valid/ready (consumer side) handshakes.
- Sits between register-file/ALU/memory result sources and a shared write-back or bus port.

---
 rtl/mux4_rr_arbiter_pkg.sv | 28 ++
 rtl/mux4_rr_arbiter_rr_pick4.sv | 28 ++
 rtl/mux4_rr_arbiter.sv | 115 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
// Holds the output-register state encoding and the select/one-hot conversions.
package mux4_rr_arbiter_pkg;

    localparam int unsigned REQ_N = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        StEmpty,
        StFull
    } state_e;

    function automatic logic [REQ_N-1:0] onehot4(input logic [SEL_W-1:0] sel);
        logic [REQ_N-1:0] oh;
        oh = 4'b0001 << sel;
        return oh;
    endfunction

    function automatic logic [SEL_W-1:0] enc4(input logic [REQ_N-1:0] oh);
        logic [SEL_W-1:0] sel;
        sel = '0;
        for (int i = 0; i < REQ_N; i++) begin
            if (oh[i]) sel = SEL_W'(i);
        end
        return sel;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request searching from ptr upward, mod 4.
// Reusable by any 4-way shared-resource arbiter.
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [REQ_N-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] win,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        win = '0;
        any = 1'b0;
        idx = '0;
        for (int k = REQ_N - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Four requesters share one mux into a one-word output register, with round-robin
// arbitration and a bounded lock that lets the current owner send back-to-back words.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [3:0]       lock,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    output logic [3:0]       ack,
    output logic [3:0]       gnt,
    output logic [1:0]       s,
    output logic [WIDTH-1:0] o,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             busy
);

    localparam logic [3:0] MaxLock = 4'(MAX_LOCK);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] o_q;
    logic [SEL_W-1:0] s_q;
    logic [REQ_N-1:0] gnt_q;
    logic [SEL_W-1:0] ptr_q;
    logic [3:0]       lock_cnt_q;

    logic [SEL_W-1:0] rr_win;
    logic             rr_any;
    logic             cap_ok;
    logic             lock_path;
    logic             capture;
    logic [SEL_W-1:0] winner;
    logic [WIDTH-1:0] word;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr_q),
        .win (rr_win),
        .any (rr_any)
    );

    // A consuming cycle may also capture, so back-to-back words have no bubble.
    assign cap_ok    = (state_q == StEmpty) || o_ready;
    // s_q names the owner only while FULL, so the state term gates it.
    assign lock_path = (state_q == StFull) && req[s_q] && lock[s_q] && (lock_cnt_q < MaxLock);
    assign capture   = cap_ok && (lock_path || rr_any);
    assign winner    = lock_path ? s_q : rr_win;

    always_comb begin
        word = I0;
        unique case (winner)
            2'd0: word = I0;
            2'd1: word = I1;
            2'd2: word = I2;
            2'd3: word = I3;
            default: word = I0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        if (cap_ok) begin
            state_d = capture ? StFull : StEmpty;
        end
    end

    // Outputs
    always_comb begin
        o_valid = (state_q == StFull);
        busy    = (state_q == StFull);
        ack     = (capture && !rst) ? onehot4(winner) : 4'b0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q        <= '0;
            s_q        <= '0;
            gnt_q      <= '0;
            ptr_q      <= '0;
            lock_cnt_q <= '0;
        end else if (capture) begin
            o_q        <= word;
            s_q        <= winner;
            gnt_q      <= onehot4(winner);
            ptr_q      <= winner + 2'd1;
            lock_cnt_q <= lock_path ? lock_cnt_q + 4'd1 : 4'd1;
        end else if (cap_ok) begin
            gnt_q      <= '0;
            lock_cnt_q <= '0;
        end
    end

    assign o   = o_q;
    assign s   = s_q;
    assign gnt = gnt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter; inputs change on the falling edge,
// ack is checked mid-low-phase and registered outputs 1 ns after the rising edge.
module tb_mux4_rr_arbiter;

    localparam logic [31:0] D0 = 32'hA0A0_0000;
    localparam logic [31:0] D1 = 32'hDEAD_BEEF;
    localparam logic [31:0] D2 = 32'hC2C2_2222;
    localparam logic [31:0] D3 = 32'hD3D3_3333;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, lock, ack, gnt;
    logic [31:0] I0, I1, I2, I3, o;
    logic [1:0]  s;
    logic        o_valid, o_ready, busy;

    int pass_cnt = 0;
    int total    = 0;

    mux4_rr_arbiter #(.WIDTH(32), .MAX_LOCK(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .lock    (lock),
        .I0      (I0),
        .I1      (I1),
        .I2      (I2),
        .I3      (I3),
        .ack     (ack),
        .gnt     (gnt),
        .s       (s),
        .o       (o),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input int i);
        case (i)
            0: return D0;
            1: return D1;
            2: return D2;
            default: return D3;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = 4'b0000; lock = 4'b0000; o_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; req = 4'b1111; o_ready = 1'b1;
        #1;
        total++; if (ack !== 4'b0000) $display("FAIL reset_ack got %b want 0000", ack); else pass_cnt++;
        total++; if (o !== 32'h0) $display("FAIL reset_o got %h want 0", o); else pass_cnt++;
        total++; if (o_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_valid got %b/%b want 0/0", o_valid, busy); else pass_cnt++;
        total++; if (gnt !== 4'b0000 || s !== 2'd0)
            $display("FAIL reset_gnt_s got %b/%0d want 0000/0", gnt, s); else pass_cnt++;
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0010; o_ready = 1'b1;
        #1;
        total++; if (ack !== 4'b0010) $display("FAIL single_ack got %b want 0010", ack); else pass_cnt++;
        @(posedge clk); #1;
        total++; if (o !== 32'hDEAD_BEEF || s !== 2'd1 || gnt !== 4'b0010 || o_valid !== 1'b1)
            $display("FAIL single_word got o=%h s=%0d gnt=%b v=%b want DEADBEEF/1/0010/1",
                     o, s, gnt, o_valid);
        else pass_cnt++;
        @(negedge clk);
        req = 4'b0000;
        @(posedge clk); #1;
        total++; if (o_valid !== 1'b0) $display("FAIL single_drop got %b want 0", o_valid); else pass_cnt++;
    endtask

    task automatic test_fairness();
        int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        req = 4'b1111; lock = 4'b0000; o_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++; if (ack !== (4'b0001 << exp_seq[i]))
                $display("FAIL fair_ack[%0d] got %b want %b", i, ack, 4'b0001 << exp_seq[i]);
            else pass_cnt++;
            @(posedge clk); #1;
            total++; if (s !== 2'(exp_seq[i]) || o !== data_of(exp_seq[i]) || o_valid !== 1'b1)
                $display("FAIL fair_word[%0d] got s=%0d o=%h v=%b want %0d/%h/1",
                         i, s, o, o_valid, exp_seq[i], data_of(exp_seq[i]));
            else pass_cnt++;
            @(negedge clk);
        end
        req = 4'b0000;
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 4'b0100; o_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 4'b1011; o_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (ack !== 4'b0000) $display("FAIL bp_ack[%0d] got %b want 0000", i, ack);
            else pass_cnt++;
            @(posedge clk); #1;
            total++; if (o !== D2 || s !== 2'd2 || gnt !== 4'b0100 || o_valid !== 1'b1)
                $display("FAIL bp_hold[%0d] got o=%h s=%0d gnt=%b want %h/2/0100", i, o, s, gnt, D2);
            else pass_cnt++;
            @(negedge clk);
        end
        o_ready = 1'b1;
        #1;
        total++; if (ack !== 4'b1000) $display("FAIL bp_release_ack got %b want 1000", ack);
        else pass_cnt++;
        @(posedge clk); #1;
        total++; if (o !== D3 || s !== 2'd3 || gnt !== 4'b1000)
            $display("FAIL bp_release_word got o=%h s=%0d gnt=%b want %h/3/1000", o, s, gnt, D3);
        else pass_cnt++;
        @(negedge clk);
        req = 4'b0000;
    endtask

    task automatic test_lock();
        int exp_seq[10] = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 2};
        do_reset();
        req = 4'b0101; lock = 4'b0001; o_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++; if (s !== 2'(exp_seq[i]) || o !== data_of(exp_seq[i]))
                $display("FAIL lock_owner[%0d] got s=%0d o=%h want %0d", i, s, o, exp_seq[i]);
            else pass_cnt++;
        end
        @(negedge clk);
    endtask

    // Runs straight after test_lock, which leaves requester 2's word held.
    task automatic test_empty();
        req = 4'b0000; lock = 4'b0000; o_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (o_valid !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0)
            $display("FAIL empty_flags got v=%b gnt=%b busy=%b want 0/0000/0", o_valid, gnt, busy);
        else pass_cnt++;
        total++; if (o !== D2 || s !== 2'd2)
            $display("FAIL empty_hold got o=%h s=%0d want %h/2", o, s, D2);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0001; o_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 4'b0000; o_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total++; if (o !== 32'h0 || o_valid !== 1'b0 || gnt !== 4'b0000 || s !== 2'd0)
            $display("FAIL midrst_async got o=%h v=%b gnt=%b s=%0d want 0/0/0000/0", o, o_valid, gnt, s);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0; req = 4'b1000; o_ready = 1'b1;
        #1;
        total++; if (ack !== 4'b1000) $display("FAIL midrst_ack got %b want 1000", ack); else pass_cnt++;
        @(posedge clk); #1;
        total++; if (s !== 2'd3 || o !== D3 || o_valid !== 1'b1)
            $display("FAIL midrst_word got s=%0d o=%h v=%b want 3/%h/1", s, o, o_valid, D3);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; lock = 4'b0000; o_ready = 1'b0;
        I0 = D0; I1 = D1; I2 = D2; I3 = D3;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_lock();
        test_empty();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
